exu_fpu_wb_ctl: RTL and testbench

- Writeback stage directly downstream of the FPU execute control.
- Tracks the destination register of the single in-flight FPU op and captures the result and fflags when the FPU signals finish.
- Arbitrates the one FP register-file write port against FP load writeback, which always has priority.
- Drives a busy scoreboard for issue and the fflags-accrue strobe for the CSR block.

---
 rtl/exu_fpu_wb_ctl.sv | 171 +++++++++++++++++
 tb/tb_exu_fpu_wb_ctl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_fpu_wb_ctl.sv
// FPU writeback control: tracks the single in-flight FPU destination,
// buffers finished results, and shares the FP regfile write port with
// FP load writeback (loads always win the port).
module exu_fpu_wb_ctl #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        flush_lower,
  input  logic        fpu_issue_valid,
  input  logic [4:0]  fpu_issue_rd,
  input  logic        fpu_finish,
  input  logic [31:0] fpu_result,
  input  logic [4:0]  fpu_fflags,
  input  logic        lsu_fp_wb_valid,
  input  logic [4:0]  lsu_fp_wb_rd,
  input  logic [31:0] lsu_fp_wb_data,
  output logic        fpu_issue_ready,
  output logic [31:0] fpr_busy,
  output logic        fpr_wen,
  output logic [4:0]  fpr_waddr,
  output logic [31:0] fpr_wdata,
  output logic        fflags_accrue_valid,
  output logic [4:0]  fflags_accrue
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  typedef enum logic {
    IDLE     = 1'b0,
    INFLIGHT = 1'b1
  } state_t;

  state_t        state_q;
  logic [4:0]    tag_q;
  logic [4:0]    rd_mem  [DEPTH];
  logic [31:0]   res_mem [DEPTH];
  logic [4:0]    flg_mem [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [31:0]   busy_q;
  logic [31:0]   busy_nxt;

  logic inflight;
  logic fifo_nempty;
  logic flush_kill;
  logic push;
  logic pop;
  logic issue_take;

  // Circular pointer advance that wraps after the last entry
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign inflight    = (state_q == INFLIGHT);
  assign fifo_nempty = (count_q != '0);
  assign flush_kill  = inflight && flush_lower;
  assign push        = inflight && fpu_finish && !flush_lower;
  assign issue_take  = fpu_issue_valid && !flush_lower && (!inflight || fpu_finish);
  assign pop         = !lsu_fp_wb_valid && fifo_nempty;

  // Counting the in-flight op as occupied space means a finish always has a slot
  assign fpu_issue_ready = ({1'b0, count_q} + {{CW{1'b0}}, inflight}) < DEPTH_W;
  assign fpr_busy        = busy_q;

  // Tag FSM: remembers the destination of the single op the FPU is working on
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= IDLE;
      tag_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (issue_take) begin
            state_q <= INFLIGHT;
            tag_q   <= fpu_issue_rd;
          end
        end
        INFLIGHT: begin
          if (flush_lower) begin
            state_q <= IDLE;
          end else if (fpu_finish) begin
            if (issue_take) begin
              tag_q <= fpu_issue_rd;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Result buffer storage; contents are only meaningful under count_q
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr_q]  <= tag_q;
      res_mem[wr_ptr_q] <= fpu_result;
      flg_mem[wr_ptr_q] <= fpu_fflags;
    end
  end

  // Result buffer pointers and occupancy
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Scoreboard next value: clears first so a same-index set on issue wins
  always_comb begin
    busy_nxt = busy_q;
    if (pop)        busy_nxt[rd_mem[rd_ptr_q]] = 1'b0;
    if (flush_kill) busy_nxt[tag_q] = 1'b0;
    if (issue_take) busy_nxt[fpu_issue_rd] = 1'b1;
  end

  // Scoreboard register
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) busy_q <= '0;
    else        busy_q <= busy_nxt;
  end

  // Write port mux: FP loads first, then the oldest buffered FPU result
  always_comb begin
    fpr_wen             = 1'b0;
    fpr_waddr           = '0;
    fpr_wdata           = '0;
    fflags_accrue_valid = 1'b0;
    fflags_accrue       = '0;
    if (lsu_fp_wb_valid) begin
      fpr_wen   = 1'b1;
      fpr_waddr = lsu_fp_wb_rd;
      fpr_wdata = lsu_fp_wb_data;
    end else if (fifo_nempty) begin
      fpr_wen             = 1'b1;
      fpr_waddr           = rd_mem[rd_ptr_q];
      fpr_wdata           = res_mem[rd_ptr_q];
      fflags_accrue_valid = 1'b1;
      fflags_accrue       = flg_mem[rd_ptr_q];
    end
  end

  a_finish_idle: assert property (@(posedge clk) disable iff (!rst_l)
    fpu_finish |-> inflight);
  a_issue_busy_fpu: assert property (@(posedge clk) disable iff (!rst_l)
    (fpu_issue_valid && inflight && !fpu_finish) |-> flush_lower);
  a_issue_ready: assert property (@(posedge clk) disable iff (!rst_l)
    issue_take |-> fpu_issue_ready);
  a_lsu_busy: assert property (@(posedge clk) disable iff (!rst_l)
    lsu_fp_wb_valid |-> !busy_q[lsu_fp_wb_rd]);
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_l)
    push |-> ({1'b0, count_q} < DEPTH_W));

endmodule

// File: tb/tb_exu_fpu_wb_ctl.sv
// Self-checking bench for exu_fpu_wb_ctl: directed vector table, hand
// sequences for flush / same-index / async reset, then randomized traffic
// checked against a queue-based reference model.
module tb_exu_fpu_wb_ctl;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst_l;
  logic        flush_lower;
  logic        fpu_issue_valid;
  logic [4:0]  fpu_issue_rd;
  logic        fpu_finish;
  logic [31:0] fpu_result;
  logic [4:0]  fpu_fflags;
  logic        lsu_fp_wb_valid;
  logic [4:0]  lsu_fp_wb_rd;
  logic [31:0] lsu_fp_wb_data;
  logic        fpu_issue_ready;
  logic [31:0] fpr_busy;
  logic        fpr_wen;
  logic [4:0]  fpr_waddr;
  logic [31:0] fpr_wdata;
  logic        fflags_accrue_valid;
  logic [4:0]  fflags_accrue;

  typedef struct {
    logic        flush;
    logic        iv;
    logic [4:0]  ird;
    logic        fin;
    logic [31:0] res;
    logic [4:0]  ffl;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldata;
    logic        e_ready;
    logic        e_wen;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic        e_fav;
    logic [4:0]  e_ff;
    logic [31:0] e_busy;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] res;
    logic [4:0]  fl;
  } ent_t;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  ent_t        mq[$];
  logic        m_inflight;
  logic [4:0]  m_tag;
  logic [31:0] m_busy;

  vec_t tbl[18];

  exu_fpu_wb_ctl #(.DEPTH(DEPTH)) dut (
    .clk                 (clk),
    .rst_l               (rst_l),
    .flush_lower         (flush_lower),
    .fpu_issue_valid     (fpu_issue_valid),
    .fpu_issue_rd        (fpu_issue_rd),
    .fpu_finish          (fpu_finish),
    .fpu_result          (fpu_result),
    .fpu_fflags          (fpu_fflags),
    .lsu_fp_wb_valid     (lsu_fp_wb_valid),
    .lsu_fp_wb_rd        (lsu_fp_wb_rd),
    .lsu_fp_wb_data      (lsu_fp_wb_data),
    .fpu_issue_ready     (fpu_issue_ready),
    .fpr_busy            (fpr_busy),
    .fpr_wen             (fpr_wen),
    .fpr_waddr           (fpr_waddr),
    .fpr_wdata           (fpr_wdata),
    .fflags_accrue_valid (fflags_accrue_valid),
    .fflags_accrue       (fflags_accrue)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something stalls
  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    flush_lower     = v.flush;
    fpu_issue_valid = v.iv;
    fpu_issue_rd    = v.ird;
    fpu_finish      = v.fin;
    fpu_result      = v.res;
    fpu_fflags      = v.ffl;
    lsu_fp_wb_valid = v.lv;
    lsu_fp_wb_rd    = v.lrd;
    lsu_fp_wb_data  = v.ldata;
  endtask

  function automatic vec_t idleVec();
    vec_t v;
    v = '{default: '0};
    return v;
  endfunction

  task automatic modelReset();
    mq.delete();
    m_inflight = 1'b0;
    m_tag      = '0;
    m_busy     = '0;
  endtask

  // Expected outputs for the current cycle, from the model's view of pending work
  task automatic modelExpect(inout vec_t v);
    v.e_ready = (mq.size() + int'(m_inflight)) < DEPTH;
    v.e_busy  = m_busy;
    v.e_wen = 1'b0; v.e_waddr = '0; v.e_wdata = '0; v.e_fav = 1'b0; v.e_ff = '0;
    if (v.lv) begin
      v.e_wen = 1'b1; v.e_waddr = v.lrd; v.e_wdata = v.ldata;
    end else if (mq.size() > 0) begin
      v.e_wen = 1'b1; v.e_waddr = mq[0].rd; v.e_wdata = mq[0].res;
      v.e_fav = 1'b1; v.e_ff = mq[0].fl;
    end
  endtask

  // Advance the model by one clock with the inputs that were held this cycle
  task automatic modelUpdate(input vec_t v);
    ent_t e;
    if (!v.lv && mq.size() > 0) begin
      e = mq.pop_front();
      m_busy[e.rd] = 1'b0;
    end
    if (m_inflight && v.flush) begin
      m_busy[m_tag] = 1'b0;
      m_inflight = 1'b0;
    end else if (m_inflight && v.fin) begin
      e.rd = m_tag; e.res = v.res; e.fl = v.ffl;
      mq.push_back(e);
      if (v.iv) begin
        m_tag = v.ird;
        m_busy[v.ird] = 1'b1;
      end else begin
        m_inflight = 1'b0;
      end
    end else if (!m_inflight && v.iv) begin
      m_inflight = 1'b1;
      m_tag = v.ird;
      m_busy[v.ird] = 1'b1;
    end
  endtask

  // One clock: drive at edge+1, compare at the falling edge, then step the model
  task automatic runCycle(input vec_t vin, input bit use_model);
    vec_t v;
    v = vin;
    applyStimulus(v);
    @(negedge clk);
    if (use_model) modelExpect(v);
    checkOutput("ready", 32'(fpu_issue_ready), 32'(v.e_ready));
    checkOutput("wen", 32'(fpr_wen), 32'(v.e_wen));
    checkOutput("waddr", 32'(fpr_waddr), 32'(v.e_waddr));
    checkOutput("wdata", fpr_wdata, v.e_wdata);
    checkOutput("fav", 32'(fflags_accrue_valid), 32'(v.e_fav));
    checkOutput("fflags", 32'(fflags_accrue), 32'(v.e_ff));
    checkOutput("busy", fpr_busy, v.e_busy);
    @(posedge clk);
    modelUpdate(v);
    cyc++;
    #1;
  endtask

  task automatic doReset();
    applyStimulus(idleVec());
    rst_l = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_l = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic randomCycle();
    vec_t v;
    bit   ready;
    v = idleVec();
    ready = (mq.size() + int'(m_inflight)) < DEPTH;
    if (m_inflight && $urandom_range(15) == 0) v.flush = 1'b1;
    if (m_inflight && $urandom_range(2) == 0)  v.fin = 1'b1;
    v.res = $urandom;
    v.ffl = 5'($urandom);
    if (ready && (!m_inflight || v.fin) && $urandom_range(1) == 1) begin
      v.iv  = 1'b1;
      v.ird = 5'($urandom);
    end
    if ($urandom_range(2) == 0) begin
      v.lrd = 5'($urandom);
      for (int k = 0; k < 64 && m_busy[v.lrd]; k++) v.lrd = 5'($urandom);
      if (!m_busy[v.lrd]) begin
        v.lv    = 1'b1;
        v.ldata = $urandom;
      end
    end
    runCycle(v, 1'b1);
  endtask

  initial begin
    vec_t v;
    // flush iv ird fin res ffl lv lrd ldata | ready wen waddr wdata fav ff busy
    tbl[0]  = '{1'b0,1'b1,5'd5,1'b0,32'h0,5'h0,1'b0,5'd0,32'h0,        1'b1,1'b0,5'd0,32'h0,1'b0,5'h0,32'h0};
    tbl[1]  = '{1'b0,1'b0,5'd0,1'b0,32'h0,5'h0,1'b0,5'd0,32'h0,        1'b1,1'b0,5'd0,32'h0,1'b0,5'h0,32'h20};
    tbl[2]  = '{1'b0,1'b0,5'd0,1'b0,32'h0,5'h0,1'b0,5'd0,32'h0,        1'b1,1'b0,5'd0,32'h0,1'b0,5'h0,32'h20};
    tbl[3]  = '{1'b0,1'b0,5'd0,1'b1,32'h3F800000,5'h01,1'b0,5'd0,32'h0, 1'b1,1'b0,5'd0,32'h0,1'b0,5'h0,32'h20};
    tbl[4]  = '{1'b0,1'b0,5'd0,1'b0,32'h0,5'h0,1'b0,5'd0,32'h0,        1'b1,1'b1,5'd5,32'h3F800000,1'b1,5'h01,32'h20};
    tbl[5]  = '{1'b0,1'b0,5'd0,1'b0,32'h0,5'h0,1'b0,5'd0,32'h0,        1'b1,1'b0,5'd0,32'h0,1'b0,5'h0,32'h0};
    tbl[6]  = '{1'b0,1'b1,5'd7,1'b0,32'h0,5'h0,1'b0,5'd0,32'h0,        1'b1,1'b0,5'd0,32'h0,1'b0,5'h0,32'h0};
    tbl[7]  = '{1'b0,1'b0,5'd0,1'b1,32'h12345678,5'h04,1'b1,5'd3,32'h40000000, 1'b1,1'b1,5'd3,32'h40000000,1'b0,5'h0,32'h80};
    tbl[8]  = '{1'b0,1'b0,5'd0,1'b0,32'h0,5'h0,1'b1,5'd3,32'h40000000, 1'b1,1'b1,5'd3,32'h40000000,1'b0,5'h0,32'h80};
    tbl[9]  = '{1'b0,1'b0,5'd0,1'b0,32'h0,5'h0,1'b0,5'd0,32'h0,        1'b1,1'b1,5'd7,32'h12345678,1'b1,5'h04,32'h80};
    tbl[10] = '{1'b0,1'b0,5'd0,1'b0,32'h0,5'h0,1'b0,5'd0,32'h0,        1'b1,1'b0,5'd0,32'h0,1'b0,5'h0,32'h0};
    tbl[11] = '{1'b0,1'b1,5'd1,1'b0,32'h0,5'h0,1'b0,5'd0,32'h0,        1'b1,1'b0,5'd0,32'h0,1'b0,5'h0,32'h0};
    tbl[12] = '{1'b0,1'b1,5'd2,1'b1,32'hAAAA0001,5'h02,1'b1,5'd10,32'h11111111, 1'b1,1'b1,5'd10,32'h11111111,1'b0,5'h0,32'h2};
    tbl[13] = '{1'b0,1'b0,5'd0,1'b0,32'h0,5'h0,1'b1,5'd10,32'h22222222, 1'b0,1'b1,5'd10,32'h22222222,1'b0,5'h0,32'h6};
    tbl[14] = '{1'b0,1'b0,5'd0,1'b1,32'hBBBB0002,5'h10,1'b1,5'd11,32'h33333333, 1'b0,1'b1,5'd11,32'h33333333,1'b0,5'h0,32'h6};
    tbl[15] = '{1'b0,1'b0,5'd0,1'b0,32'h0,5'h0,1'b0,5'd0,32'h0,        1'b0,1'b1,5'd1,32'hAAAA0001,1'b1,5'h02,32'h6};
    tbl[16] = '{1'b0,1'b0,5'd0,1'b0,32'h0,5'h0,1'b0,5'd0,32'h0,        1'b1,1'b1,5'd2,32'hBBBB0002,1'b1,5'h10,32'h4};
    tbl[17] = '{1'b0,1'b0,5'd0,1'b0,32'h0,5'h0,1'b0,5'd0,32'h0,        1'b1,1'b0,5'd0,32'h0,1'b0,5'h0,32'h0};

    doReset();
    for (int i = 0; i < 18; i++) runCycle(tbl[i], 1'b0);

    // Flush kills the op even though finish arrives in the same cycle
    v = idleVec(); v.iv = 1'b1; v.ird = 5'd9; runCycle(v, 1'b1);
    runCycle(idleVec(), 1'b1);
    v = idleVec(); v.flush = 1'b1; v.fin = 1'b1; v.res = 32'hDEADBEEF; v.ffl = 5'h1F;
    runCycle(v, 1'b1);
    checkOutput("flush_busy9", 32'(fpr_busy[9]), 32'h0);
    checkOutput("flush_ready", 32'(fpu_issue_ready), 32'h1);
    checkOutput("flush_nowrite", 32'(fpr_wen), 32'h0);
    repeat (2) runCycle(idleVec(), 1'b1);
    v = idleVec(); v.iv = 1'b1; v.ird = 5'd6; runCycle(v, 1'b1);
    checkOutput("post_flush_issue", 32'(fpr_busy[6]), 32'h1);
    v = idleVec(); v.fin = 1'b1; v.res = 32'h00000066; runCycle(v, 1'b1);
    repeat (2) runCycle(idleVec(), 1'b1);

    // Same-index: pop of rd=4 coincides with a fresh issue to rd=4
    v = idleVec(); v.iv = 1'b1; v.ird = 5'd4; runCycle(v, 1'b1);
    v = idleVec(); v.fin = 1'b1; v.res = 32'h00000044; v.ffl = 5'h08; runCycle(v, 1'b1);
    v = idleVec(); v.iv = 1'b1; v.ird = 5'd4; runCycle(v, 1'b1);
    checkOutput("same_idx_busy4", 32'(fpr_busy[4]), 32'h1);
    v = idleVec(); v.fin = 1'b1; v.res = 32'h00000045; runCycle(v, 1'b1);
    repeat (2) runCycle(idleVec(), 1'b1);
    checkOutput("same_idx_drain", fpr_busy, 32'h0);

    // Async reset with two results still buffered behind LSU traffic
    v = idleVec(); v.iv = 1'b1; v.ird = 5'd12; runCycle(v, 1'b1);
    v = idleVec(); v.fin = 1'b1; v.res = 32'h0C0C0C0C; v.iv = 1'b1; v.ird = 5'd13;
    v.lv = 1'b1; v.lrd = 5'd20; v.ldata = 32'h20202020; runCycle(v, 1'b1);
    v = idleVec(); v.lv = 1'b1; v.lrd = 5'd20; v.ldata = 32'h20202021; runCycle(v, 1'b1);
    v = idleVec(); v.fin = 1'b1; v.res = 32'h0D0D0D0D;
    v.lv = 1'b1; v.lrd = 5'd21; v.ldata = 32'h21212121; runCycle(v, 1'b1);
    checkOutput("pre_reset_full", 32'(fpu_issue_ready), 32'h0);
    #2;
    applyStimulus(idleVec());
    rst_l = 1'b0;
    #1;
    checkOutput("rst_ready", 32'(fpu_issue_ready), 32'h1);
    checkOutput("rst_wen", 32'(fpr_wen), 32'h0);
    checkOutput("rst_waddr", 32'(fpr_waddr), 32'h0);
    checkOutput("rst_wdata", fpr_wdata, 32'h0);
    checkOutput("rst_fav", 32'(fflags_accrue_valid), 32'h0);
    checkOutput("rst_fflags", 32'(fflags_accrue), 32'h0);
    checkOutput("rst_busy", fpr_busy, 32'h0);
    modelReset();
    @(posedge clk);
    @(negedge clk);
    rst_l = 1'b1;
    @(posedge clk);
    #1;
    repeat (4) runCycle(idleVec(), 1'b1);

    // Randomized traffic against the reference model
    for (int i = 0; i < 600; i++) randomCycle();
    repeat (4) runCycle(idleVec(), 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
